cost_batch_sequencer: RTL
=========================

Name: cost_batch_sequencer

Overview:
Control stage directly upstream of the cost calculator.
- Per sample: fetches the sample, pulses cost_en, waits for calculation_complete, and accumulates cost_output.
- Over a batch of 2^BATCH_LOG2 samples: produces batch sum, average and max cost, with a done pulse.
- Guards against a hung calculator with a watchdog timeout.

Parameters:
BATCH_LOG2, 4, log2 of samples per batch (batch = 16)
COST_W, 8, width of cost_output from the calculator
TIMEOUT, 64, max cycles spent in WAIT before aborting; must be >= 2
ACC_W, COST_W+BATCH_LOG2, accumulator width (derived; never overflows)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
batch_start  in  1  start a batch; honoured only in IDLE
sample_valid  in  1  upstream sample/label present on calculator inputs
sample_req  out  1  request next sample; high throughout FETCH
sample_idx  out  BATCH_LOG2  index of sample in progress
cost_en  out  1  one-cycle start pulse to cost calculator
calculation_complete  in  1  calculator done (may be pulse or held level)
cost_output  in  COST_W  calculator result, valid with calculation_complete
batch_sum  out  ACC_W  running/final cost sum
batch_avg  out  COST_W  batch_sum >> BATCH_LOG2 (truncating); valid from DONE until next batch_start
max_cost  out  COST_W  largest cost accepted in current batch
batch_done  out  1  one-cycle pulse, batch finished successfully
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on watchdog abort, cleared by batch_start

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: sample_req, cost_en, sample_idx, batch_sum, max_cost, batch_done, busy, timeout_err.
  - Watchdog timer 0; completion edge register 0.
  - Reset mid-batch discards all progress.
- States: IDLE, FETCH, START, WAIT, DONE. All outputs except batch_avg are registered or decoded from state.
- IDLE:
  - On batch_start: clear batch_sum, max_cost, sample_idx and timeout_err; go to FETCH.
  - batch_start in any other state is ignored.
- FETCH:
  - sample_req=1.
  - sample_valid high in the same cycle is accepted; go to START. Otherwise stay.
- START:
  - cost_en=1 for exactly this one cycle.
  - Clear watchdog timer; go to WAIT.
- WAIT:
  - Completion is the rising edge of calculation_complete (current high, previous-cycle registered value low).
  - A level held high from the previous sample is never re-counted.
  - The edge register updates every cycle in every state.
  - On completion:
    - batch_sum += zero-extended cost_output.
    - max_cost = max(max_cost, cost_output).
    - If sample_idx == 2^BATCH_LOG2-1, go to DONE.
    - Otherwise sample_idx++ and go to FETCH.
  - Without completion: timer increments.
    - When timer == TIMEOUT-1, set timeout_err=1 and go to IDLE.
    - No batch_done; batch_sum, max_cost and sample_idx hold their partial values.
  - If completion and the timeout condition occur in the same cycle, completion wins.
- DONE: batch_done=1 for one cycle; go to IDLE.
- Holding of results: batch_sum, max_cost and batch_avg hold after DONE until the next batch_start.
- calculation_complete outside WAIT: ignored apart from updating the edge register.
- Arithmetic: unsigned throughout. ACC_W bits hold 2^BATCH_LOG2 × (2^COST_W − 1) exactly, so no saturation logic is needed.
- Minimum per-sample latency is 3 cycles (FETCH, START, WAIT) when sample_valid and the completion edge arrive immediately.

Test Plan:
1. Reset: assert rst mid-WAIT (sample_idx=5, batch_sum=40) -> same cycle (async): all outputs 0, busy=0; next batch_start starts from idx 0.
2. Uniform batch: 16 samples, cost_output=5, complete pulse 10 cycles after each cost_en -> batch_sum=80, batch_avg=5, max_cost=5, exactly 16 cost_en pulses, exactly one batch_done.
3. Mixed costs 0..15 in order -> batch_sum=120, batch_avg=7 (truncated), max_cost=15; sample_req low during START/WAIT.
4. Full-scale costs 255 ×16 -> batch_sum=4080 (12 bits), batch_avg=255, no wrap.
5. Held completion: calculator keeps calculation_complete high until its next cost_en; costs 1..16 -> each accepted once, batch_sum=136. batch_start pulsed while busy -> ignored.
6. Watchdog: sample 3 never completes -> timeout_err=1 exactly 64 cycles after the START cycle; busy=0, no batch_done, batch_sum holds 3 costs. Next batch_start clears timeout_err; a clean batch then completes normally.

Source files
------------

// File: rtl/cost_batch_sequencer.sv
// Sequences one batch of samples through the cost calculator and accumulates sum, average and max.
// A watchdog aborts the batch if the calculator hangs in WAIT.
module cost_batch_sequencer #(
  parameter int BATCH_LOG2 = 4,
  parameter int COST_W     = 8,
  parameter int TIMEOUT    = 64,
  parameter int ACC_W      = COST_W + BATCH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  batch_start,
  input  logic                  sample_valid,
  output logic                  sample_req,
  output logic [BATCH_LOG2-1:0] sample_idx,
  output logic                  cost_en,
  input  logic                  calculation_complete,
  input  logic [COST_W-1:0]     cost_output,
  output logic [ACC_W-1:0]      batch_sum,
  output logic [COST_W-1:0]     batch_avg,
  output logic [COST_W-1:0]     max_cost,
  output logic                  batch_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [BATCH_LOG2-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             comp_q;
  logic             comp_rise;

  // A level left high by the previous sample is not a new completion.
  assign comp_rise = calculation_complete & ~comp_q;

  assign sample_req = (state == S_FETCH);
  assign cost_en    = (state == S_START);
  assign batch_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign batch_avg  = COST_W'(batch_sum >> BATCH_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      comp_q      <= 1'b0;
      sample_idx  <= '0;
      batch_sum   <= '0;
      max_cost    <= '0;
      timeout_err <= 1'b0;
    end else begin
      comp_q <= calculation_complete;
      case (state)
        S_IDLE: begin
          if (batch_start) begin
            batch_sum   <= '0;
            max_cost    <= '0;
            sample_idx  <= '0;
            timeout_err <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (sample_valid) state <= S_START;
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident watchdog expiry.
          if (comp_rise) begin
            batch_sum <= batch_sum + ACC_W'(cost_output);
            if (cost_output > max_cost) max_cost <= cost_output;
            if (sample_idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              sample_idx <= sample_idx + 1'b1;
              state      <= S_FETCH;
            end
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
